// File: rtl/fx2_gpio_out.sv
// FX2 slave-FIFO GPIO command port: reads opcode/argument pairs from FIFO2,
// updates an 8-bit GPIO register and optionally acks {gpio, err/count} to FIFO4.
// Ports: FX2_CLK, FX2_RST (sync, active high), FX2_FD (bidir data),
//   FX2_flags [0]=FIFO2 has data [2]=FIFO4 not full, FX2_PA_7 (unused),
//   FX2_SLRD/FX2_SLWR strobes, PA_2 SLOE, PA_3 tied 1, PA_6 PKTEND,
//   PA_5/PA_4 FIFOADR, gpio_output.
// Config: define FX2_GPIO_ACK_EN to enable the FIFO4 ack packet.
module fx2_gpio_out #(
  parameter logic [7:0] GPIO_RESET_VALUE = 8'h00
) (
  input  logic       FX2_CLK,
  input  logic       FX2_RST,
  inout  wire  [7:0] FX2_FD,
  input  logic [2:0] FX2_flags,
  input  logic       FX2_PA_7,
  output logic       FX2_SLRD,
  output logic       FX2_SLWR,
  output logic       FX2_PA_2,
  output logic       FX2_PA_3,
  output logic       FX2_PA_4,
  output logic       FX2_PA_5,
  output logic       FX2_PA_6,
  output logic [7:0] gpio_output
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_TURN,
    S_TX0,
    S_TX1,
    S_PKT
  } state_t;

  state_t     r_state;
  logic [7:0] r_gpio;
  logic [7:0] r_op;
  logic       r_phase;
  logic       r_err;
  logic [6:0] r_cnt;

  logic w_has;
  logic w_room;
  logic w_rd;
  logic w_ld;
  logic w_or;
  logic w_clr;
  logic w_xor;

  assign w_has  = FX2_flags[0];
  assign w_room = FX2_flags[2];

  // Strobes follow the flags in the same cycle so a byte is moved
  // exactly when the FX2 can take/give it; reset forces them idle.
  assign w_rd = (r_state == S_RX) & w_has & ~FX2_RST;

  assign w_ld  = (r_op == 8'h01);
  assign w_or  = (r_op == 8'h02);
  assign w_clr = (r_op == 8'h03);
  assign w_xor = (r_op == 8'h04);

  always_ff @(posedge FX2_CLK) begin
    if (FX2_RST) begin
      r_state <= S_IDLE;
      r_gpio  <= GPIO_RESET_VALUE;
      r_op    <= 8'h00;
      r_phase <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 7'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_has) r_state <= S_RX;
        end
        S_RX: begin
          if (w_has) begin
            if (!r_phase) begin
              r_op    <= FX2_FD;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_cnt   <= r_cnt + 7'd1;
              unique case (1'b1)
                w_ld:    r_gpio <= FX2_FD;
                w_or:    r_gpio <= r_gpio | FX2_FD;
                w_clr:   r_gpio <= r_gpio & ~FX2_FD;
                w_xor:   r_gpio <= r_gpio ^ FX2_FD;
                default: r_err  <= 1'b1;
              endcase
            end
          end else begin
`ifdef FX2_GPIO_ACK_EN
            r_state <= S_TURN;
`else
            r_state <= S_IDLE;
            r_err   <= 1'b0;
            r_cnt   <= 7'd0;
            r_phase <= 1'b0;
`endif
          end
        end
        S_TURN: r_state <= S_TX0;
        S_TX0: begin
          if (w_room) r_state <= S_TX1;
        end
        S_TX1: begin
          if (w_room) r_state <= S_PKT;
        end
        S_PKT: begin
          // A dangling opcode dies here with the packet.
          r_state <= S_IDLE;
          r_err   <= 1'b0;
          r_cnt   <= 7'd0;
          r_phase <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gpio_output = r_gpio;
  assign FX2_SLRD    = ~w_rd;
  assign FX2_PA_3    = 1'b1;
  assign FX2_PA_4    = 1'b0;

`ifdef FX2_GPIO_ACK_EN
  logic       w_tx;
  logic       w_f4;
  logic [7:0] w_dout;

  assign w_tx   = ((r_state == S_TX0) | (r_state == S_TX1)) & ~FX2_RST;
  assign w_f4   = ((r_state == S_TURN) | (r_state == S_TX0) |
                   (r_state == S_TX1) | (r_state == S_PKT)) & ~FX2_RST;
  assign w_dout = (r_state == S_TX0) ? r_gpio : {r_err, r_cnt};

  assign FX2_SLWR = ~(w_tx & w_room);
  assign FX2_PA_2 = w_f4;
  assign FX2_PA_5 = w_f4;
  assign FX2_PA_6 = ~((r_state == S_PKT) & ~FX2_RST);
  assign FX2_FD   = w_tx ? w_dout : 8'hzz;

  logic w_unused;
  assign w_unused = &{1'b0, FX2_PA_7, FX2_flags[1]};
`else
  assign FX2_SLWR = 1'b1;
  assign FX2_PA_2 = 1'b0;
  assign FX2_PA_5 = 1'b0;
  assign FX2_PA_6 = 1'b1;
  assign FX2_FD   = 8'hzz;

  logic w_unused;
  assign w_unused = &{1'b0, FX2_PA_7, FX2_flags[2:1],
                      r_err, r_cnt};
`endif

endmodule

// File: tb/tb_fx2_gpio_out.sv
// Bench for fx2_gpio_out: FIFO2/FIFO4 models, directed table,
// hand sequences and random packets against a packet-level model.
module tb_fx2_gpio_out;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] flags;
  logic       pa7;
  wire  [7:0] fd;
  logic       slrd, slwr;
  logic       pa2, pa3, pa4, pa5, pa6;
  logic [7:0] gpio;
  logic [7:0] tb_fd;

  always #5 clk = ~clk;

  // Host side drives the bus whenever SLOE is asserted.
  assign fd = pa2 ? 8'hzz : tb_fd;

  fx2_gpio_out #(.GPIO_RESET_VALUE(8'hA5)) dut (
    .FX2_CLK(clk), .FX2_RST(rst), .FX2_FD(fd),
    .FX2_flags(flags), .FX2_PA_7(pa7),
    .FX2_SLRD(slrd), .FX2_SLWR(slwr),
    .FX2_PA_2(pa2), .FX2_PA_3(pa3), .FX2_PA_4(pa4),
    .FX2_PA_5(pa5), .FX2_PA_6(pa6), .gpio_output(gpio)
  );

  typedef struct {
    logic [7:0] b [6];
    int         len;
    logic [7:0] g;
    logic [7:0] a1;
  } vec_t;

  vec_t tbl [4];

  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;
  int pkts = 0;
  int pk0;
  logic f4_ok;
  logic [7:0] q2[$];
  logic [7:0] w4[$];
  logic [7:0] hist[$];
  logic [7:0] pk[$];
  logic [7:0] exp_w[$];
  logic [7:0] last_g;
  logic [7:0] mg;
  logic [7:0] s_fd;
  logic [1:0] s_adr;
  logic       s_wr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic cycle();
    logic rd, pe;
    @(negedge clk);
    flags = {f4_ok, 1'b0, q2.size() != 0};
    tb_fd = (q2.size() != 0) ? q2[0] : 8'h96;
    #1;
    rd    = !slrd;
    s_wr  = !slwr;
    pe    = !pa6;
    s_fd  = fd;
    s_adr = {pa5, pa4};
    if (rd && s_adr != 2'b00) viol++;
    if (rd && pa2) viol++;
    if (rd && s_wr) viol++;
`ifdef FX2_GPIO_ACK_EN
    if (s_wr && s_adr != 2'b10) viol++;
    if (s_wr && !f4_ok) viol++;
    if (pe && s_adr != 2'b10) viol++;
`else
    if (s_wr || pe || s_adr != 2'b00) viol++;
`endif
    if (s_wr) w4.push_back(s_fd);
    if (pe) pkts++;
    @(posedge clk);
    if (rd && q2.size() != 0) void'(q2.pop_front());
    #1;
    if (gpio !== last_g) begin
      hist.push_back(gpio);
      last_g = gpio;
    end
  endtask

  // Packet-level reference: walks pk two bytes at a time.
  task automatic model();
    logic e;
    int   c;
    e = 1'b0;
    c = 0;
    for (int i = 0; i + 1 < pk.size(); i += 2) begin
      case (pk[i])
        8'h01:   mg = pk[i+1];
        8'h02:   mg = mg | pk[i+1];
        8'h03:   mg = mg & ~pk[i+1];
        8'h04:   mg = mg ^ pk[i+1];
        default: e = 1'b1;
      endcase
      c = (c + 1) % 128;
    end
    exp_w.delete();
`ifdef FX2_GPIO_ACK_EN
    exp_w.push_back(mg);
    exp_w.push_back({e, c[6:0]});
`endif
  endtask

  task automatic run_pkt(input string nm);
    int post;
    bit ok;
    post = 0;
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      cycle();
      if (q2.size() == 0) post++;
`ifdef FX2_GPIO_ACK_EN
      if (q2.size() == 0 && pkts > pk0) begin
        ok = 1'b1;
        break;
      end
`else
      if (post >= 4) begin
        ok = 1'b1;
        break;
      end
`endif
    end
    chk({nm, " done"}, 32'(ok), 32'd1);
  endtask

  task automatic chk_w(input string nm);
    chk({nm, " nwr"}, w4.size(), exp_w.size());
    chk({nm, " npkt"}, pkts - pk0, exp_w.size() / 2);
    for (int i = 0; i < exp_w.size(); i++)
      if (i < w4.size()) chk({nm, " wr"}, w4[i], exp_w[i]);
    chk({nm, " gpio"}, gpio, mg);
  endtask

  task automatic play(input string nm);
    model();
    w4.delete();
    pk0 = pkts;
    foreach (pk[i]) q2.push_back(pk[i]);
    run_pkt(nm);
    chk_w(nm);
  endtask

  initial begin
    tbl[0] = '{'{8'h04, 8'hFF, 8'h7E, 8'h11, 8'h05, 8'h00},
               5, 8'h0F, 8'h82};
    tbl[1] = '{'{8'h01, 8'h81, 8'h04, 8'h18, 8'h00, 8'h00},
               4, 8'h99, 8'h02};
    tbl[2] = '{'{8'h03, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00},
               4, 8'h90, 8'h82};
    tbl[3] = '{'{8'h02, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00},
               2, 8'h9F, 8'h01};

    rst = 1'b1;
    pa7 = 1'b0;
    f4_ok = 1'b1;
    flags = 3'b000;
    tb_fd = 8'h96;
    last_g = 8'hA5;
    repeat (3) cycle();
    @(negedge clk);
    #1;
    chk("rst gpio", gpio, 8'hA5);
    chk("rst slrd", slrd, 1'b1);
    chk("rst slwr", slwr, 1'b1);
    chk("rst pktend", pa6, 1'b1);
    chk("rst sloe", pa2, 1'b0);
    chk("rst pa3", pa3, 1'b1);
    chk("rst adr", {pa5, pa4}, 2'b00);
    chk("rst fd", fd, 8'h96);
    rst = 1'b0;
    mg = 8'hA5;
    hist.delete();

    pk = '{8'h01, 8'h3C, 8'h02, 8'hC0, 8'h03, 8'h0C};
    play("p034");
    chk("p034 nhist", hist.size(), 3);
    if (hist.size() == 3) begin
      chk("p034 h0", hist[0], 8'h3C);
      chk("p034 h1", hist[1], 8'hFC);
      chk("p034 h2", hist[2], 8'hF0);
    end
    chk("p034 gk", gpio, 8'hF0);
`ifdef FX2_GPIO_ACK_EN
    if (w4.size() == 2) begin
      chk("p034 a0", w4[0], 8'hF0);
      chk("p034 a1", w4[1], 8'h03);
    end
`endif

    for (int t = 0; t < 4; t++) begin
      pk.delete();
      for (int j = 0; j < tbl[t].len; j++) pk.push_back(tbl[t].b[j]);
      play($sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d gk", t), gpio, tbl[t].g);
`ifdef FX2_GPIO_ACK_EN
      if (w4.size() == 2) begin
        chk($sformatf("tbl%0d a0", t), w4[0], tbl[t].g);
        chk($sformatf("tbl%0d a1", t), w4[1], tbl[t].a1);
      end
`endif
    end

`ifdef FX2_GPIO_ACK_EN
    begin
      int nwr, bad, wt;
      f4_ok = 1'b0;
      pk = '{8'h01, 8'h5A};
      model();
      w4.delete();
      pk0 = pkts;
      foreach (pk[i]) q2.push_back(pk[i]);
      wt = 0;
      s_adr = 2'b00;
      while (s_adr != 2'b10 && wt < 100) begin
        cycle();
        wt++;
      end
      chk("hold reach", 32'(wt < 100), 32'd1);
      cycle();
      nwr = 0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        cycle();
        if (s_wr) nwr++;
        if (s_fd !== 8'h5A) bad++;
      end
      chk("hold nowr", nwr, 0);
      chk("hold fd", bad, 0);
      f4_ok = 1'b1;
      run_pkt("hold");
      chk_w("hold");
    end
`endif

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 9);
      pk.delete();
      for (int j = 0; j < n; j++)
        pk.push_back((j % 2 == 0) ? 8'($urandom_range(0, 6))
                                  : 8'($urandom));
      play($sformatf("rnd%0d", r));
    end

    pk.delete();
    for (int j = 0; j < 129; j++) begin
      pk.push_back(8'h02);
      pk.push_back(8'h00);
    end
    play("wrap");
`ifdef FX2_GPIO_ACK_EN
    if (w4.size() == 2) chk("wrap a1", w4[1], 8'h01);
`endif

    begin
      int wt;
      q2.push_back(8'h01);
      q2.push_back(8'h3C);
      w4.delete();
      pk0 = pkts;
      wt = 0;
      while (q2.size() != 1 && wt < 50) begin
        cycle();
        wt++;
      end
      chk("mrst reach", 32'(wt < 50), 32'd1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("mrst gpio", gpio, 8'hA5);
      mg = 8'hA5;
      pk = '{8'h3C, 8'h02, 8'h41};
      model();
      q2.push_back(8'h02);
      q2.push_back(8'h41);
      run_pkt("mrst");
      chk_w("mrst");
      chk("mrst gk", gpio, 8'hA5);
`ifdef FX2_GPIO_ACK_EN
      if (w4.size() == 2) chk("mrst a1", w4[1], 8'h81);
`endif
    end

    chk("protocol", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fx2_gpio_out.md
FX2_GPIO_OUT -- requirements
Module: fx2_gpio_out

Interface
REQ-001 SHALL have parameter GPIO_RESET_VALUE, default 8'h00, which is the value of gpio_output after reset.
REQ-002 SHALL have port FX2_CLK, input, 1 bit: the single clock (FX2 IFCLK); all logic is on its rising edge.
REQ-003 SHALL have port FX2_RST, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port FX2_FD, inout, 8 bits: FX2 FIFO data bus.
REQ-005 SHALL have port FX2_flags, input, 3 bits: [0] high = FIFO2 has data; [2] high = FIFO4 not full; [1] unused.
REQ-006 SHALL have port FX2_PA_7, input, 1 bit: FIFO5 flag, unused.
REQ-007 SHALL have ports FX2_SLRD and FX2_SLWR, outputs, 1 bit each: active-low read strobe and write strobe.
REQ-008 SHALL have ports FX2_PA_2, FX2_PA_3 and FX2_PA_6, outputs, 1 bit each: PA_2 is SLOE (active low), PA_3 is tied 1, PA_6 is PKTEND (active low).
REQ-009 SHALL have ports FX2_PA_5 and FX2_PA_4, outputs, 1 bit each: FIFOADR[1:0]; 00 selects FIFO2 and 10 selects FIFO4.
REQ-010 SHALL have port gpio_output, output, 8 bits: the registered GPIO output value.

Function
REQ-011 SHALL implement the states IDLE, RX, TURN, TX0, TX1 and PKT; every transition occurs on the FX2_CLK rising edge.
REQ-012 SHALL transition IDLE->RX when FX2_flags[0]=1, and RX->TURN when FX2_flags[0]=0.
REQ-013 SHALL transition TURN->TX0 unconditionally; TX0->TX1 and TX1->PKT each only when FX2_flags[2]=1 (otherwise hold); PKT->IDLE unconditionally.
REQ-014 SHALL drive FIFOADR to 00 in IDLE and RX, and to 10 in TURN, TX0, TX1 and PKT.
REQ-015 SHALL assert SLOE in IDLE and RX only, and SHALL release FX2_FD (high-Z) whenever SLOE is asserted.
REQ-016 SHALL assert SLRD only in RX with FX2_flags[0]=1; each such cycle consumes exactly one byte from FX2_FD.
REQ-017 SHALL treat consumed bytes as alternating opcode and argument, starting each packet with an opcode.
REQ-018 SHALL apply the following opcodes to gpio_output on the cycle after the argument is consumed: 01 = load arg; 02 = OR arg; 03 = AND ~arg; 04 = XOR arg.
REQ-019 SHALL ignore any other opcode, consume its argument, and set the sticky err flag.
REQ-020 SHALL increment a 7-bit cmd_count on each completed opcode/argument pair (valid or not), wrapping from 127 to 0.
REQ-021 SHALL discard a trailing opcode with no argument at packet end, without counting it or flagging it.
REQ-022 SHALL drive FX2_FD in TX0 and TX1 only, with SLWR asserted only in the cycle of an accepted write (FX2_flags[2]=1).
REQ-023 SHALL write gpio_output as the TX0 byte and {err, cmd_count} as the TX1 byte.
REQ-024 SHALL hold its state with no strobe while FX2_flags[2]=0 in TX0/TX1.
REQ-025 SHALL assert PKTEND for exactly one cycle, in PKT.
REQ-026 SHALL clear err, cmd_count and the opcode/argument phase in PKT.
REQ-027 SHALL ignore FIFO2 data arriving in TURN through PKT until IDLE is re-entered.
REQ-028 SHALL never change gpio_output except via REQ-018 or reset.

Reset
REQ-029 SHALL, while FX2_RST=1 at a clock edge: set state=IDLE, gpio_output=GPIO_RESET_VALUE, err=0, cmd_count=0, phase=opcode; FX2_SLRD=1, FX2_SLWR=1, PA_6=1, PA_2=0, FIFOADR=00, FX2_FD high-Z.
REQ-030 SHALL abandon any reset asserted mid-packet without writing a partial ack, with unread FIFO2 bytes left for the next packet.

Configuration
REQ-031 SHALL use the macro FX2_GPIO_ACK_EN: when defined, TURN, TX0, TX1 and PKT behave as specified above.
REQ-032 SHALL, when FX2_GPIO_ACK_EN is undefined, go RX->IDLE directly: FIFO4 is never addressed, SLWR and PKTEND are never asserted, FX2_FD is never driven, and err/cmd_count clear on the RX->IDLE transition.

Verification
REQ-033 SHALL cover: reset with GPIO_RESET_VALUE=8'hA5 -> gpio_output=A5, SLRD/SLWR/PKTEND high, FD high-Z.
REQ-034 SHALL cover: packet 01 3C 02 C0 03 0C -> gpio_output 3C, then FC, then F0; ack bytes F0, 03, then one PKTEND pulse.
REQ-035 SHALL cover: packet 04 FF 7E 11 05 -> gpio toggled to ~prior value; ack second byte 82 (err=1, count=2); trailing 05 is ignored.
REQ-036 SHALL cover: FIFO4 flag held low 10 cycles in TX0 -> no SLWR and FD stable; after release, exactly 2 writes.
REQ-037 SHALL cover: 129 pairs of 02 00 -> ack second byte 01 (count wrapped).
REQ-038 SHALL cover: FX2_RST pulse after opcode byte mid-RX -> gpio_output reset, no ack packet, next packet parsed from opcode phase.
